// File: rtl/fpjh_pkg.sv
// Shared constants and types for the fpjh fragment/aggregation receive path.
// Header bit-fields describe the first 32-bit beat of every frame.
package fpjh_pkg;

  localparam int HDR_LEN_LSB    = 16;
  localparam int HDR_LEN_W      = 12;
  localparam int HDR_TYPE_W     = 16;
  localparam int FRAG_MAX_BYTES = 841;
  localparam int BEAT_CNT_W     = 12;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arbState_t;

endpackage

// File: rtl/fpjh_rr_pick.sv
// Combinational round-robin picker: returns the first requester strictly above
// lastIdx, wrapping to the lowest requester when none is found above it.
module fpjh_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] lastIdx,
  output logic [N-1:0]  grant
);

  logic [N-1:0] grantHi;
  logic [N-1:0] grantLo;

  // Scanning downward leaves the lowest qualifying index in each vector.
  always_comb begin
    grantHi = '0;
    grantLo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grantLo    = '0;
        grantLo[i] = 1'b1;
        if (i > int'(lastIdx)) begin
          grantHi    = '0;
          grantHi[i] = 1'b1;
        end
      end
    end
    grant = (grantHi != '0) ? grantHi : grantLo;
  end

endmodule

// File: rtl/fpjh_rx_arb.sv
// Frame-granular round-robin arbiter in front of the fragment receiver.
// Forwards whole frames, captures first-beat header fields, flags overlong frames.
module fpjh_rx_arb
  import fpjh_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int MAX_BEATS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       i_cfg_en,
  input  logic [NUM_CH-1:0]       i_axis_tvalid,
  input  logic [32*NUM_CH-1:0]    i_axis_tdata,
  input  logic [4*NUM_CH-1:0]     i_axis_tkeep,
  input  logic [NUM_CH-1:0]       i_axis_tlast,
  output logic [NUM_CH-1:0]       i_axis_tready,
  output logic                    o_axis_tvalid,
  output logic [31:0]             o_axis_tdata,
  output logic [3:0]              o_axis_tkeep,
  output logic                    o_axis_tlast,
  input  logic                    o_axis_tready,
  output logic [NUM_CH-1:0]       o_grant,
  output logic                    o_busy,
  output logic                    o_hdr_vld,
  output logic [HDR_LEN_W-1:0]    o_hdr_len,
  output logic [HDR_TYPE_W-1:0]   o_hdr_type,
  output logic [2:0]              o_hdr_ch,
  output logic                    o_err_long,
  output logic [31:0]             o_frame_cnt
);

  localparam int IW = $clog2(NUM_CH);
  localparam logic [BEAT_CNT_W-1:0] MAX_CNT = BEAT_CNT_W'(MAX_BEATS);

  arbState_t             state;
  logic [NUM_CH-1:0]     grant;
  logic [IW-1:0]         grantIdx;
  logic [IW-1:0]         lastIdx;
  logic                  firstBeat;
  logic [BEAT_CNT_W-1:0] beatCnt;
  logic [NUM_CH-1:0]     pickGrant;
  logic [IW-1:0]         pickIdx;
  logic                  xfer;

  fpjh_rr_pick #(.N(NUM_CH), .IW(IW)) u_pick (
    .req     (i_axis_tvalid & i_cfg_en),
    .lastIdx (lastIdx),
    .grant   (pickGrant)
  );

  always_comb begin
    pickIdx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (pickGrant[k]) pickIdx = IW'(k);
    end
  end

  // NOTE: grant is all-zero in IDLE, so the one-hot mux needs no state term.
  always_comb begin
    o_axis_tvalid = 1'b0;
    o_axis_tdata  = '0;
    o_axis_tkeep  = '0;
    o_axis_tlast  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) begin
        o_axis_tvalid = i_axis_tvalid[k];
        o_axis_tdata  = i_axis_tdata[32*k +: 32];
        o_axis_tkeep  = i_axis_tkeep[4*k +: 4];
        o_axis_tlast  = i_axis_tlast[k];
      end
    end
  end

  assign i_axis_tready = grant & {NUM_CH{o_axis_tready}};
  assign xfer          = o_axis_tvalid & o_axis_tready;
  assign o_grant       = grant;
  assign o_busy        = (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grantIdx    <= '0;
      lastIdx     <= IW'(NUM_CH - 1);
      firstBeat   <= 1'b0;
      beatCnt     <= '0;
      o_hdr_vld   <= 1'b0;
      o_hdr_len   <= '0;
      o_hdr_type  <= '0;
      o_hdr_ch    <= '0;
      o_err_long  <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_hdr_vld  <= 1'b0;
      o_err_long <= 1'b0;
      case (state)
        IDLE: begin
          if (pickGrant != '0) begin
            state     <= BUSY;
            grant     <= pickGrant;
            grantIdx  <= pickIdx;
            firstBeat <= 1'b1;
            beatCnt   <= '0;
          end
        end
        BUSY: begin
          if (xfer) begin
            firstBeat <= 1'b0;
            if (firstBeat) begin
              o_hdr_vld  <= 1'b1;
              o_hdr_len  <= o_axis_tdata[HDR_LEN_LSB +: HDR_LEN_W];
              o_hdr_type <= o_axis_tdata[HDR_TYPE_W-1:0];
              o_hdr_ch   <= 3'(grantIdx);
            end
            if (beatCnt < MAX_CNT) beatCnt <= beatCnt + 1'b1;
            // Saturation guarantees this count value is crossed once per frame.
            if (beatCnt == MAX_CNT - 1'b1 && !o_axis_tlast) o_err_long <= 1'b1;
            if (o_axis_tlast) begin
              state       <= IDLE;
              grant       <= '0;
              lastIdx     <= grantIdx;
              o_frame_cnt <= o_frame_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpjh_rx_arb.sv
// Self-checking bench for fpjh_rx_arb: directed tables/sequences plus
// randomized traffic against a frame-level reference model.
module tb_fpjh_rx_arb;
  import fpjh_pkg::*;

  localparam int N    = 4;
  localparam int MAXB = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    cfgEn;
  logic [N-1:0]    inValid, inLast, inReady;
  logic [32*N-1:0] inData;
  logic [4*N-1:0]  inKeep;
  logic            outValid, outLast, outReady;
  logic [31:0]     outData;
  logic [3:0]      outKeep;
  logic [N-1:0]    grant;
  logic            busy, hdrVld, errLong;
  logic [11:0]     hdrLen;
  logic [15:0]     hdrType;
  logic [2:0]      hdrCh;
  logic [31:0]     frameCnt;

  logic        chValid [N];
  logic        chLast  [N];
  logic [31:0] chData  [N];
  logic [3:0]  chKeep  [N];

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      inValid[k]         = chValid[k];
      inLast[k]          = chLast[k];
      inData[32*k +: 32] = chData[k];
      inKeep[4*k +: 4]   = chKeep[k];
    end
  end

  fpjh_rx_arb #(.NUM_CH(N), .MAX_BEATS(MAXB)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_cfg_en      (cfgEn),
    .i_axis_tvalid (inValid),
    .i_axis_tdata  (inData),
    .i_axis_tkeep  (inKeep),
    .i_axis_tlast  (inLast),
    .i_axis_tready (inReady),
    .o_axis_tvalid (outValid),
    .o_axis_tdata  (outData),
    .o_axis_tkeep  (outKeep),
    .o_axis_tlast  (outLast),
    .o_axis_tready (outReady),
    .o_grant       (grant),
    .o_busy        (busy),
    .o_hdr_vld     (hdrVld),
    .o_hdr_len     (hdrLen),
    .o_hdr_type    (hdrType),
    .o_hdr_ch      (hdrCh),
    .o_err_long    (errLong),
    .o_frame_cnt   (frameCnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    nChecks++;
    if (act !== want) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    for (int k = 0; k < N; k++) begin
      chValid[k] = 1'b0;
      chLast[k]  = 1'b0;
      chData[k]  = '0;
      chKeep[k]  = '0;
    end
    cfgEn    = '1;
    outReady = 1'b1;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic setBeat(input int ch, input logic [31:0] d, input logic l);
    chValid[ch] = 1'b1;
    chData[ch]  = d;
    chLast[ch]  = l;
    chKeep[ch]  = 4'hF;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] last;
    logic         rdy;
    logic [N-1:0] expGrant;
    logic [N-1:0] expTready;
    logic         expLast;
    logic [31:0]  expCnt;
  } vec_t;

  vec_t tbl [16];

  // Reference model state for the random phase.
  logic [31:0] srcBeat [N][12];
  int          srcLen  [N];
  int          srcPos  [N];
  logic        mBusy, mFirst, expHdrVld, expErr;
  int          mOwner, mLast, mBeats;
  logic [31:0] mFrames;
  logic [11:0] expHdrLen;
  logic [15:0] expHdrType;
  logic [2:0]  expHdrCh;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat;
    logic [31:0] bpData [5];
    logic hs, lastB, nextHdrVld, nextErr;
    logic [31:0] b;

    // Round robin, all channels continuously offering 2-beat frames.
    tbl[0]  = '{4'hF, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 0};
    tbl[1]  = '{4'hF, 4'h0, 1'b1, 4'h1, 4'h1, 1'b0, 0};
    tbl[2]  = '{4'hF, 4'h1, 1'b1, 4'h1, 4'h1, 1'b1, 0};
    tbl[3]  = '{4'hF, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1};
    tbl[4]  = '{4'hF, 4'h0, 1'b1, 4'h2, 4'h2, 1'b0, 1};
    tbl[5]  = '{4'hF, 4'h2, 1'b1, 4'h2, 4'h2, 1'b1, 1};
    tbl[6]  = '{4'hF, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 2};
    tbl[7]  = '{4'hF, 4'h0, 1'b1, 4'h4, 4'h4, 1'b0, 2};
    tbl[8]  = '{4'hF, 4'h4, 1'b1, 4'h4, 4'h4, 1'b1, 2};
    tbl[9]  = '{4'hF, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 3};
    tbl[10] = '{4'hF, 4'h0, 1'b1, 4'h8, 4'h8, 1'b0, 3};
    tbl[11] = '{4'hF, 4'h8, 1'b1, 4'h8, 4'h8, 1'b1, 3};
    tbl[12] = '{4'hF, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 4};
    tbl[13] = '{4'hF, 4'h0, 1'b1, 4'h1, 4'h1, 1'b0, 4};
    tbl[14] = '{4'hF, 4'h1, 1'b1, 4'h1, 4'h1, 1'b1, 4};
    tbl[15] = '{4'hF, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 5};

    // ---- Reset state ----
    doReset();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_hdr_vld", hdrVld, 0);
    check("rst_hdr_len", hdrLen, 0);
    check("rst_hdr_type", hdrType, 0);
    check("rst_hdr_ch", hdrCh, 0);
    check("rst_err_long", errLong, 0);
    check("rst_frame_cnt", frameCnt, 0);

    // ---- Single channel, 3-beat frame on ch1 ----
    setBeat(1, 32'h0034_0001, 1'b0);
    #1 check("sc_idle_tready", inReady, 0);
    tick();
    check("sc_grant", grant, 4'b0010);
    check("sc_busy", busy, 1);
    check("sc_out_data", outData, 32'h0034_0001);
    check("sc_tready", inReady, 4'b0010);
    tick();
    check("sc_hdr_vld", hdrVld, 1);
    check("sc_hdr_len", hdrLen, 12'h034);
    check("sc_hdr_type", hdrType, 16'h0001);
    check("sc_hdr_ch", hdrCh, 1);
    setBeat(1, 32'hAAAA_0001, 1'b0);
    tick();
    check("sc_hdr_vld_pulse", hdrVld, 0);
    setBeat(1, 32'hBBBB_0002, 1'b1);
    #1 check("sc_out_last", outLast, 1);
    tick();
    check("sc_frame_cnt", frameCnt, 1);
    check("sc_bubble_grant", grant, 0);
    check("sc_bubble_busy", busy, 0);
    setBeat(1, 32'h0010_0000, 1'b0);
    tick();
    check("sc_regrant", grant, 4'b0010);

    // ---- Round robin table ----
    doReset();
    for (int k = 0; k < N; k++) setBeat(k, 32'hC000_0000 | k, 1'b0);
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < N; k++) begin
        chValid[k] = tbl[r].valid[k];
        chLast[k]  = tbl[r].last[k];
      end
      outReady = tbl[r].rdy;
      #1;
      check($sformatf("rr%0d_grant", r), grant, tbl[r].expGrant);
      check($sformatf("rr%0d_busy", r), busy, tbl[r].expGrant != 0);
      check($sformatf("rr%0d_tready", r), inReady, tbl[r].expTready);
      check($sformatf("rr%0d_last", r), outLast, tbl[r].expLast);
      check($sformatf("rr%0d_cnt", r), frameCnt, tbl[r].expCnt);
      tick();
    end

    // ---- Backpressure: 5-beat ch2 frame with ready toggling 1010 ----
    doReset();
    for (int i = 0; i < 5; i++) bpData[i] = 32'hB000_0000 | (32'(i) << 8) | 32'(i);
    setBeat(2, bpData[0], 1'b0);
    tick();
    check("bp_grant", grant, 4'b0100);
    setBeat(0, 32'hDEAD_0000, 1'b0);
    beat = 0;
    for (int c = 0; beat < 5 && c < 20; c++) begin
      outReady = (c % 2 == 0);
      setBeat(2, bpData[beat], beat == 4);
      #1;
      check($sformatf("bp%0d_data", c), outData, bpData[beat]);
      check($sformatf("bp%0d_valid", c), outValid, 1);
      check($sformatf("bp%0d_tready", c), inReady, outReady ? 4'b0100 : 4'b0000);
      tick();
      if (outReady) beat++;
    end
    check("bp_beats", beat, 5);
    check("bp_frame_cnt", frameCnt, 1);
    chValid[2] = 1'b0;
    outReady   = 1'b1;
    tick();
    check("bp_next_owner", grant, 4'b0001);

    // ---- Enable mask ----
    doReset();
    cfgEn = 4'b1010;
    for (int k = 0; k < N; k++) setBeat(k, 32'h0000_0100 | k, 1'b0);
    tick();
    check("en_first", grant, 4'b0010);
    cfgEn = 4'b1000;
    tick();
    setBeat(1, 32'h0000_0201, 1'b1);
    tick();
    check("en_ch1_done_cnt", frameCnt, 1);
    check("en_ch1_done_grant", grant, 0);
    setBeat(1, 32'h0000_0101, 1'b0);
    tick();
    check("en_second", grant, 4'b1000);
    setBeat(3, 32'h0000_0203, 1'b1);
    tick();
    check("en_ch3_done_cnt", frameCnt, 2);
    setBeat(3, 32'h0000_0103, 1'b0);
    cfgEn = 4'b1010;
    tick();
    check("en_third", grant, 4'b0010);

    // ---- Overlength: 10 beats on ch2 with MAX_BEATS=8 ----
    doReset();
    setBeat(2, 32'h0028_0000, 1'b0);
    tick();
    check("ol_grant", grant, 4'b0100);
    for (int i = 0; i < 10; i++) begin
      setBeat(2, 32'h0028_0000 | i, i == 9);
      #1 check($sformatf("ol%0d_tready", i), inReady, 4'b0100);
      tick();
      check($sformatf("ol%0d_err", i), errLong, i == 7);
      check($sformatf("ol%0d_cnt", i), frameCnt, i == 9);
    end
    chValid[2] = 1'b0;
    tick();
    check("ol_err_after", errLong, 0);

    // ---- Reset mid-frame ----
    doReset();
    setBeat(0, 32'h0010_0000, 1'b1);
    tick();
    tick();
    check("rm_first_cnt", frameCnt, 1);
    setBeat(0, 32'h0020_0002, 1'b0);
    tick();
    tick();
    tick();
    check("rm_hdr_type_pre", hdrType, 16'h0002);
    check("rm_grant_pre", grant, 4'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_grant", grant, 0);
    check("rm_busy", busy, 0);
    check("rm_cnt", frameCnt, 0);
    check("rm_hdr_len", hdrLen, 0);
    check("rm_hdr_type", hdrType, 0);
    setBeat(3, 32'h0030_0000, 1'b0);
    tick();
    check("rm_ch0_first", grant, 4'b0001);

    // ---- Randomized traffic against the reference model ----
    doReset();
    for (int k = 0; k < N; k++) begin
      srcLen[k] = 0;
      srcPos[k] = 0;
    end
    mBusy = 1'b0; mFirst = 1'b0; mOwner = 0; mLast = N - 1; mBeats = 0;
    mFrames = 0; expHdrVld = 1'b0; expErr = 1'b0;
    expHdrLen = '0; expHdrType = '0; expHdrCh = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 15) == 0) cfgEn = N'($urandom);
      outReady = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if (srcPos[k] >= srcLen[k] && $urandom_range(0, 5) == 0) begin
          srcLen[k] = $urandom_range(1, 11);
          srcPos[k] = 0;
          srcBeat[k][0] = {4'h0, 12'($urandom), 16'($urandom)};
          for (int i = 1; i < 12; i++) srcBeat[k][i] = $urandom;
        end
        if (srcPos[k] < srcLen[k]) begin
          chValid[k] = ($urandom_range(0, 3) != 0);
          chData[k]  = srcBeat[k][srcPos[k]];
          chLast[k]  = (srcPos[k] == srcLen[k] - 1);
          chKeep[k]  = 4'($urandom);
        end else begin
          chValid[k] = 1'b0;
          chLast[k]  = 1'b0;
          chData[k]  = '0;
          chKeep[k]  = '0;
        end
      end
      #1;
      check("rnd_grant", grant, mBusy ? (4'b0001 << mOwner) : 4'b0000);
      check("rnd_busy", busy, mBusy);
      check("rnd_valid", outValid, mBusy ? chValid[mOwner] : 1'b0);
      check("rnd_data", outData, mBusy ? chData[mOwner] : 32'h0);
      check("rnd_keep", outKeep, mBusy ? chKeep[mOwner] : 4'h0);
      check("rnd_last", outLast, mBusy ? chLast[mOwner] : 1'b0);
      check("rnd_tready", inReady, mBusy ? (4'(outReady) << mOwner) : 4'b0000);
      check("rnd_hdr_vld", hdrVld, expHdrVld);
      check("rnd_hdr_len", hdrLen, expHdrLen);
      check("rnd_hdr_type", hdrType, expHdrType);
      check("rnd_hdr_ch", hdrCh, expHdrCh);
      check("rnd_err_long", errLong, expErr);
      check("rnd_frame_cnt", frameCnt, mFrames);

      nextHdrVld = 1'b0;
      nextErr    = 1'b0;
      if (mBusy) begin
        hs = chValid[mOwner] && outReady;
        if (hs) begin
          b     = srcBeat[mOwner][srcPos[mOwner]];
          lastB = (srcPos[mOwner] == srcLen[mOwner] - 1);
          srcPos[mOwner]++;
          if (mFirst) begin
            nextHdrVld = 1'b1;
            expHdrLen  = b[27:16];
            expHdrType = b[15:0];
            expHdrCh   = 3'(mOwner);
            mFirst     = 1'b0;
          end
          mBeats++;
          if (mBeats == MAXB && !lastB) nextErr = 1'b1;
          if (lastB) begin
            mBusy = 1'b0;
            mLast = mOwner;
            mFrames++;
          end
        end
      end else begin
        for (int d = 1; d <= N; d++) begin
          if (!mBusy && chValid[(mLast + d) % N] && cfgEn[(mLast + d) % N]) begin
            mOwner = (mLast + d) % N;
            mBusy  = 1'b1;
            mFirst = 1'b1;
            mBeats = 0;
          end
        end
      end
      expHdrVld = nextHdrVld;
      expErr    = nextErr;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/fpjh_rx_arb.md
# fpjh_rx_arb

Frame-granular round-robin arbiter that shares the single fragment/aggregation receive datapath between `NUM_CH` AXI-Stream sources. It sits directly in front of the fragment-parsing receiver and forwards whole frames without interleaving. It captures the first-beat header fields (frame type, fragment length) of each granted frame for the downstream parser and status logic. It also counts beats per frame and flags frames that run past a configured maximum.

## Interface
Parameters:
- `NUM_CH`, default 4: number of requesting input streams (2..8).
- `MAX_BEATS`, default 256: beat count at which a frame is flagged too long. 256 × 4 B covers the 841 B maximum fragment plus header and trailer.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset. Synchronous, active-high; one clock, one reset.
- `i_cfg_en` in `NUM_CH`: per-channel enable mask, sampled only in IDLE.
- `i_axis_tvalid` in `NUM_CH`: per-channel valid.
- `i_axis_tdata` in `32*NUM_CH`: channel k occupies bits `[32k+31:32k]`.
- `i_axis_tkeep` in `4*NUM_CH`: channel k occupies bits `[4k+3:4k]`.
- `i_axis_tlast` in `NUM_CH`: per-channel last.
- `i_axis_tready` out `NUM_CH`: per-channel ready.
- `o_axis_tvalid`, `o_axis_tdata`[31:0], `o_axis_tkeep`[3:0], `o_axis_tlast`, all out: merged stream.
- `o_axis_tready` in 1: ready from the receiver.
- `o_grant` out `NUM_CH`: one-hot current owner; all zero in IDLE.
- `o_busy` out 1: high in BUSY.
- `o_hdr_vld` out 1: one-cycle pulse when the first beat of a frame is accepted.
- `o_hdr_len` out 12: `tdata[27:16]` of the first beat (pure fragment length).
- `o_hdr_type` out 16: `tdata[15:0]` of the first beat; bit 0 set means an aggregation frame.
- `o_hdr_ch` out 3: index of the channel that supplied the header.
- `o_err_long` out 1: one-cycle pulse when the beat count reaches `MAX_BEATS` without tlast.
- `o_frame_cnt` out 32: total frames completed, wraps modulo 2^32.

## Operation
- State machine with two states:
  - IDLE → BUSY when `(i_axis_tvalid & i_cfg_en) != 0`. The winner is the first requesting, enabled channel searching upward from `last_grant+1` modulo `NUM_CH`. The winner is registered into `grant`.
  - BUSY → IDLE on a handshake (`o_axis_tvalid & o_axis_tready`) with `o_axis_tlast=1`. At that point `last_grant <= grant` and `o_frame_cnt` increments.
- In BUSY the granted channel is a combinational passthrough:
  - `o_axis_* = i_axis_*[g]`.
  - `i_axis_tready[g] = o_axis_tready`.
  - All other `i_axis_tready` bits are 0.
- In IDLE:
  - `o_axis_tvalid`, `o_axis_tlast`, `o_axis_tdata` and `o_axis_tkeep` are 0.
  - All `i_axis_tready` bits are 0.
- First-beat flag:
  - Set on entering BUSY.
  - Cleared on the first handshake.
  - That handshake registers `o_hdr_len`, `o_hdr_type` and `o_hdr_ch`, and pulses `o_hdr_vld` in the following cycle.
- Beat counter:
  - 12 bits, cleared on entering BUSY, increments per handshake, saturates at `MAX_BEATS`.
  - `o_err_long` pulses once, on the cycle after the handshake that makes count = `MAX_BEATS` with tlast=0.
  - The frame keeps its grant after the error; the arbiter never forces tlast or drops beats.
- `i_cfg_en` changes during BUSY do not affect the current frame. A channel disabled mid-frame completes its frame.
- A single-beat frame (tlast on the first beat) produces both `o_hdr_vld` and a frame count increment.

## Timing
- Reset values:
  - `o_grant`, `o_busy`, `o_hdr_*`, `o_err_long`, `o_frame_cnt`: 0.
  - `last_grant = NUM_CH-1`, so channel 0 wins first.
  - State IDLE.
- Arbitration latency: request visible in cycle t → grant and `o_busy` in t+1 → first beat can transfer in t+1.
- One idle bubble cycle after every frame (BUSY→IDLE→BUSY). Maximum throughput is L/(L+1) for L-beat frames.
- Data path latency through the arbiter is 0 cycles; the arbiter adds no registers on `tdata`.
- A tvalid drop on the owner mid-frame holds the grant; the arbiter waits indefinitely.
- Reset asserted mid-frame:
  - Next cycle is IDLE with all outputs at reset values.
  - The partial frame is abandoned; the source must restart it.

## Structure
- Shared package `fpjh_pkg` holds:
  - header bit-field constants (`HDR_LEN_LSB=16`, `HDR_LEN_W=12`, `HDR_TYPE_W=16`);
  - `FRAG_MAX_BYTES=841`;
  - the state enum.
- One sub-module, `fpjh_rr_pick`: a combinational round-robin priority picker (request vector, last grant → one-hot grant). It is reusable by the transmit-side scheduler.

## Test plan
- **Single channel.** Ch1 sends a 3-beat frame; beat 0 = `0x0034_0001`.
  - Grant = `4'b0010` one cycle after tvalid.
  - `o_hdr_len=0x034`, `o_hdr_type=0x0001`, `o_hdr_ch=1`.
  - `o_frame_cnt=1`, with a bubble after the frame.
- **Round robin.** All 4 channels hold 2-beat frames continuously.
  - Grant order is 0,1,2,3,0.
  - No beat interleaving: `o_axis_tlast` appears every 2nd transfer.
- **Backpressure.** `o_axis_tready` toggles 1010 during a 5-beat frame.
  - Output data sequence is identical to the input.
  - `i_axis_tready` of the owner mirrors `o_axis_tready`; non-owners stay 0.
- **Enable mask.**
  - `i_cfg_en=4'b1010` with all channels valid → only ch1 and ch3 are granted.
  - Clearing bit 1 mid-frame on ch1 → ch1 still completes.
- **Overlength.** `MAX_BEATS=8`, ch2 sends 10 beats.
  - `o_err_long` pulses exactly once, one cycle after the 8th handshake.
  - All 10 beats pass; `o_frame_cnt` increments at the 10th beat.
- **Reset mid-frame.** `rst` for 1 cycle at beat 2 of a ch0 frame.
  - Next cycle: `o_grant=0`, `o_frame_cnt=0`.
  - The next request from ch3 wins ahead of ch0 only if ch0 is not requesting; otherwise ch0 wins first.
